dw_mailbox_responder: RTL and testbench



---
 rtl/dw_mailbox_responder_pkg.sv | 37 +++
 rtl/dw_mailbox_responder_fifo.sv | 63 ++++++
 rtl/dw_mailbox_responder.sv | 151 +++++++++++++++
 tb/tb_dw_mailbox_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dw_mailbox_responder_pkg.sv
// +----------------------------------------------------------------------+
// | dw_mailbox_responder_pkg: register map, STATUS/CONTROL bit positions   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package dw_mailbox_responder_pkg;

  localparam logic [1:0] MBX_RXDATA  = 2'd0;
  localparam logic [1:0] MBX_TXDATA  = 2'd1;
  localparam logic [1:0] MBX_STATUS  = 2'd2;
  localparam logic [1:0] MBX_CONTROL = 2'd3;

  localparam int ST_RXCNT_LSB = 0;
  localparam int ST_TXCNT_LSB = 8;
  localparam int ST_RXEMPTY   = 16;
  localparam int ST_TXFULL    = 17;
  localparam int ST_TXOVF     = 18;
  localparam int ST_RXOVF     = 19;

  localparam int CTRL_CLRRX    = 0;
  localparam int CTRL_CLRTX    = 1;
  localparam int CTRL_CLRFLAGS = 2;
  localparam int CTRL_IRQEN    = 3;

  // Disabled byte lanes are stored as zero rather than left undefined.
  function automatic logic [31:0] maskBytes(input logic [31:0] data, input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dw_mailbox_responder_fifo.sv
// +----------------------------------------------------------------------+
// | mailbox_fifo: synchronous FIFO with clear; head reads 0 when empty     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     iCLK,
  input  logic                     iRSTn,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iData,
  input  logic                     iPop,
  input  logic                     iClear,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic [WIDTH-1:0]         oHead
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rWrPtr;
  logic [AW-1:0]    rRdPtr;
  logic [CW-1:0]    rCount;
  logic             wDoPush;
  logic             wDoPop;

  // Full/empty come from pre-edge state, so a same-cycle pop never frees room for a push.
  assign oFull   = (rCount == CW'(DEPTH));
  assign oEmpty  = (rCount == '0);
  assign wDoPush = iPush & ~oFull;
  assign wDoPop  = iPop & ~oEmpty;
  assign oCount  = rCount;
  assign oHead   = oEmpty ? '0 : mem[rRdPtr];

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else if (iClear) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else begin
      if (wDoPush) rWrPtr <= rWrPtr + 1'b1;
      if (wDoPop)  rRdPtr <= rRdPtr + 1'b1;
      rCount <= rCount + CW'(wDoPush) - CW'(wDoPop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (wDoPush) mem[rWrPtr] <= iData;
  end

endmodule

`default_nettype wire

// File: rtl/dw_mailbox_responder.sv
// +----------------------------------------------------------------------+
// | dw_mailbox_responder: Dw-bus mailbox with RX/TX FIFOs to off-core logic|
// | Optional MAILBOX_IRQ_EN adds oIrq and CONTROL bit3.  Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module dw_mailbox_responder
  import dw_mailbox_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF200100,
  parameter int          DEPTH     = 16
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  input  logic        iRxValid,
  input  logic [31:0] iRxData,
  output logic        oRxReady,
  output logic        oTxValid,
  output logic [31:0] oTxData,
  input  logic        iTxReady
`ifdef MAILBOX_IRQ_EN
  ,
  output logic        oIrq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    wReg;
  logic          wRxPop;
  logic          wTxPush;
  logic          wCtrlWr;
  logic          wClrRx;
  logic          wClrTx;
  logic          wClrFlags;
  logic          wRxFull;
  logic          wRxEmpty;
  logic          wTxFull;
  logic          wTxEmpty;
  logic [CW-1:0] wRxCount;
  logic [CW-1:0] wTxCount;
  logic [31:0]   wRxHead;
  logic [31:0]   wTxHead;
  logic [31:0]   wStatus;
  logic          rTxOvf;
  logic          rRxOvf;
  logic [1:0]    wAddrLsb_unused;

  assign wAddrLsb_unused = iAddress[1:0];

  assign oHit = (iAddress[31:4] == BASE_ADDR[31:4]);
  assign wReg = iAddress[3:2];

  assign wRxPop    = oHit & iReadEnable  & (wReg == MBX_RXDATA);
  assign wTxPush   = oHit & iWriteEnable & (wReg == MBX_TXDATA) & (iByteEnable != 4'b0000);
  assign wCtrlWr   = oHit & iWriteEnable & (wReg == MBX_CONTROL) & iByteEnable[0];
  assign wClrRx    = wCtrlWr & iWriteData[CTRL_CLRRX];
  assign wClrTx    = wCtrlWr & iWriteData[CTRL_CLRTX];
  assign wClrFlags = wCtrlWr & iWriteData[CTRL_CLRFLAGS];

  mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) uRxFifo (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iPush  (iRxValid),
    .iData  (iRxData),
    .iPop   (wRxPop),
    .iClear (wClrRx),
    .oFull  (wRxFull),
    .oEmpty (wRxEmpty),
    .oCount (wRxCount),
    .oHead  (wRxHead)
  );

  mailbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) uTxFifo (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iPush  (wTxPush),
    .iData  (maskBytes(iWriteData, iByteEnable)),
    .iPop   (iTxReady),
    .iClear (wClrTx),
    .oFull  (wTxFull),
    .oEmpty (wTxEmpty),
    .oCount (wTxCount),
    .oHead  (wTxHead)
  );

  assign oRxReady = ~wRxFull;
  assign oTxValid = ~wTxEmpty;
  assign oTxData  = wTxHead;

  always_comb begin
    wStatus = '0;
    wStatus[ST_RXCNT_LSB +: 5] = 5'(wRxCount);
    wStatus[ST_TXCNT_LSB +: 5] = 5'(wTxCount);
    wStatus[ST_RXEMPTY]        = wRxEmpty;
    wStatus[ST_TXFULL]         = wTxFull;
    wStatus[ST_TXOVF]          = rTxOvf;
    wStatus[ST_RXOVF]          = rRxOvf;
  end

  always_comb begin
    oReadData = '0;
    if (oHit) begin
      case (wReg)
        MBX_RXDATA: oReadData = wRxHead;
        MBX_STATUS: oReadData = wStatus;
        default:    oReadData = '0;
      endcase
    end
  end

  // A fresh overflow outranks a same-cycle flag clear.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rTxOvf <= 1'b0;
      rRxOvf <= 1'b0;
    end else begin
      if (wTxPush & wTxFull)       rTxOvf <= 1'b1;
      else if (wClrFlags)          rTxOvf <= 1'b0;
      if (iRxValid & wRxFull)      rRxOvf <= 1'b1;
      else if (wClrFlags)          rRxOvf <= 1'b0;
    end
  end

`ifdef MAILBOX_IRQ_EN
  logic rIrqEn;
  logic rIrq;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rIrqEn <= 1'b0;
      rIrq   <= 1'b0;
    end else begin
      if (wCtrlWr) rIrqEn <= iWriteData[CTRL_IRQEN];
      rIrq <= rIrqEn & ((wRxCount != '0) | rTxOvf | rRxOvf);
    end
  end

  assign oIrq = rIrq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dw_mailbox_responder.sv
// +----------------------------------------------------------------------+
// | tb_dw_mailbox_responder: directed self-checking bench for the mailbox |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dw_mailbox_responder;

  localparam logic [31:0] A_RX   = 32'hFF200100;
  localparam logic [31:0] A_TX   = 32'hFF200104;
  localparam logic [31:0] A_ST   = 32'hFF200108;
  localparam logic [31:0] A_CTRL = 32'hFF20010C;

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic        iReadEnable = 1'b0;
  logic        iWriteEnable = 1'b0;
  logic [3:0]  iByteEnable = 4'h0;
  logic [31:0] iAddress = 32'h0;
  logic [31:0] iWriteData = 32'h0;
  logic [31:0] oReadData;
  logic        oHit;
  logic        iRxValid = 1'b0;
  logic [31:0] iRxData = 32'h0;
  logic        oRxReady;
  logic        oTxValid;
  logic [31:0] oTxData;
  logic        iTxReady = 1'b0;
`ifdef MAILBOX_IRQ_EN
  logic        oIrq;
`endif

  int total = 0;
  int bad = 0;

  always #5 iCLK = ~iCLK;

  dw_mailbox_responder dut (
    .iCLK         (iCLK),
    .iRSTn        (iRSTn),
    .iReadEnable  (iReadEnable),
    .iWriteEnable (iWriteEnable),
    .iByteEnable  (iByteEnable),
    .iAddress     (iAddress),
    .iWriteData   (iWriteData),
    .oReadData    (oReadData),
    .oHit         (oHit),
    .iRxValid     (iRxValid),
    .iRxData      (iRxData),
    .oRxReady     (oRxReady),
    .oTxValid     (oTxValid),
    .oTxData      (oTxData),
    .iTxReady     (iTxReady)
`ifdef MAILBOX_IRQ_EN
    ,
    .oIrq         (oIrq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic busIdle();
    iReadEnable  = 1'b0;
    iWriteEnable = 1'b0;
    iByteEnable  = 4'h0;
    iAddress     = 32'h0;
    iWriteData   = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] addr);
    iWriteEnable = 1'b0;
    iReadEnable  = 1'b1;
    iAddress     = addr;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    iReadEnable  = 1'b0;
    iWriteEnable = 1'b1;
    iAddress     = addr;
    iWriteData   = data;
    iByteEnable  = be;
  endtask

  initial begin
    // Reset state
    #12;
    @(negedge iCLK);
    iRSTn = 1'b1;
    busRead(A_ST);
    #1 check("reset_status", oReadData, 32'h00010000);
    check("reset_hit", 32'(oHit), 32'h1);
    busRead(A_RX);
    #1 check("reset_rxdata", oReadData, 32'h0);
    check("reset_rxready", 32'(oRxReady), 32'h1);
    check("reset_txvalid", 32'(oTxValid), 32'h0);
    check("reset_txdata", oTxData, 32'h0);
    busRead(32'hFF200110);
    #1 check("miss_hit", 32'(oHit), 32'h0);
    check("miss_data", oReadData, 32'h0);
    busIdle();

    // Empty RXDATA read must not pop anything
    busRead(A_RX);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("empty_read_nopop", oReadData, 32'h00010000);

    // RX beat then CPU read
    busIdle();
    iRxValid = 1'b1;
    iRxData  = 32'hDEADBEEF;
    @(negedge iCLK);
    iRxValid = 1'b0;
    busRead(A_ST);
    #1 check("rx1_status", oReadData, 32'h00000001);
    @(negedge iCLK);
    busRead(A_RX);
    #1 check("rx1_data", oReadData, 32'hDEADBEEF);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("rx1_popped", oReadData, 32'h00010000);

    // Byte-enable 0 write is ignored
    busWrite(A_TX, 32'hFFFFFFFF, 4'b0000);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("tx_be0_nopush", oReadData, 32'h00010000);

    // TX write with partial byte enables
    busWrite(A_TX, 32'h12345678, 4'b0011);
    @(negedge iCLK);
    busIdle();
    #1 check("tx1_valid", 32'(oTxValid), 32'h1);
    check("tx1_data", oTxData, 32'h00005678);
    iTxReady = 1'b1;
    @(negedge iCLK);
    iTxReady = 1'b0;
    #1 check("tx1_drained", 32'(oTxValid), 32'h0);
    check("tx1_data_empty", oTxData, 32'h0);

    // Overfill TX
    for (int i = 0; i < 17; i++) begin
      busWrite(A_TX, 32'hA0 + 32'(i), 4'hF);
      @(negedge iCLK);
    end
    busRead(A_ST);
    #1 check("txfull_status", oReadData, 32'h00071000);
    check("txfull_head", oTxData, 32'h000000A0);
    busWrite(A_CTRL, 32'h6, 4'h1);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("ctrl_clear_status", oReadData, 32'h00010000);
    check("ctrl_clear_txvalid", 32'(oTxValid), 32'h0);

    // Fill RX
    busIdle();
    for (int i = 0; i < 16; i++) begin
      iRxValid = 1'b1;
      iRxData  = 32'h100 + 32'(i);
      @(negedge iCLK);
    end
    iRxValid = 1'b0;
    busRead(A_ST);
    #1 check("rxfull_status", oReadData, 32'h00000010);
    check("rxfull_ready", 32'(oRxReady), 32'h0);

    // Producer held while full, CPU pops the same cycle
    @(negedge iCLK);
    iRxValid = 1'b1;
    iRxData  = 32'h55;
    busRead(A_RX);
    #1 check("rxfull_head", oReadData, 32'h00000100);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("rxovf_status", oReadData, 32'h0008000F);
    check("rxovf_ready", 32'(oRxReady), 32'h1);
    @(negedge iCLK);
    iRxValid = 1'b0;
    #1 check("rx_accept_after", oReadData, 32'h00080010);
    busRead(A_RX);
    #1 check("rx_order", oReadData, 32'h00000101);
    @(negedge iCLK);
    busWrite(A_CTRL, 32'h7, 4'h1);
    @(negedge iCLK);
    busRead(A_ST);
    #1 check("clear_all", oReadData, 32'h00010000);

    // Load both FIFOs with 5 entries, then reset asynchronously
    for (int i = 0; i < 5; i++) begin
      iRxValid = 1'b1;
      iRxData  = 32'h200 + 32'(i);
      busWrite(A_TX, 32'h300 + 32'(i), 4'hF);
      @(negedge iCLK);
    end
    iRxValid = 1'b0;
    busRead(A_ST);
    #1 check("five_each", oReadData, 32'h00000505);
    check("five_txdata", oTxData, 32'h00000300);
    #1 iRSTn = 1'b0;
    #1 check("async_rst_status", oReadData, 32'h00010000);
    check("async_rst_txvalid", 32'(oTxValid), 32'h0);
    check("async_rst_txdata", oTxData, 32'h0);
    check("async_rst_rxready", 32'(oRxReady), 32'h1);
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);
    #1 check("post_rst_status", oReadData, 32'h00010000);
    busIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
